// File: rtl/serializer_pkg.sv
// Shared definitions for the parallel-to-serial shifter.
package serializer_pkg;

  // Two-state controller: waiting for a word, or shifting one out.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Shortest word length that is shifted out; shorter requests are dropped.
  localparam int MIN_LEN = 3;

endpackage

// File: rtl/serializer.sv
// MSB-first parallel-to-serial converter with a per-word bit count.
// One word in flight at a time. Requests seen while busy are dropped.
// Every output is driven straight from a flop.
module serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MOD_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [MOD_W-1:0] data_mod_i,
  input  logic             data_val_i,
  output logic             ser_data_o,
  output logic             ser_data_val_o,
  output logic             busy_o
);

  // The counter is one bit wider than data_mod_i, so a full-width word
  // (data_mod_i == 0) still fits without wrapping.
  localparam logic [MOD_W:0] FULL_LEN = (MOD_W+1)'(WIDTH);
  localparam logic [MOD_W:0] MIN_N    = (MOD_W+1)'(MIN_LEN);
  localparam logic [MOD_W:0] ONE      = (MOD_W+1)'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [MOD_W:0]   cnt_q, cnt_d;
  logic             ser_data_q, ser_data_d;
  logic             ser_val_q, ser_val_d;
  logic             busy_q, busy_d;
  logic [MOD_W:0]   n_eff;

  // Effective word length: a count of zero means the full width.
  always_comb begin
    n_eff = (data_mod_i == '0) ? FULL_LEN : {1'b0, data_mod_i};
  end

  // Next-state logic. The first bit goes to the output flop on the accept
  // edge, so the shift register holds the word already shifted by one.
  // The counter holds the number of bits still to show, including the one
  // on the output now. Output flops default to 0 whenever nothing is valid.
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    ser_data_d = 1'b0;
    ser_val_d  = 1'b0;
    busy_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_val_i && (n_eff >= MIN_N)) begin
          state_d    = SEND;
          shreg_d    = {data_i[WIDTH-2:0], 1'b0};
          cnt_d      = n_eff;
          ser_data_d = data_i[WIDTH-1];
          ser_val_d  = 1'b1;
          busy_d     = 1'b1;
        end
      end
      SEND: begin
        if (cnt_q == ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          shreg_d = '0;
        end else begin
          cnt_d      = cnt_q - ONE;
          shreg_d    = {shreg_q[WIDTH-2:0], 1'b0};
          ser_data_d = shreg_q[WIDTH-1];
          ser_val_d  = 1'b1;
          busy_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers. Reset clears them at once, with no clock.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      ser_data_q <= 1'b0;
      ser_val_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      ser_data_q <= ser_data_d;
      ser_val_q  <= ser_val_d;
      busy_q     <= busy_d;
    end
  end

  assign ser_data_o     = ser_data_q;
  assign ser_data_val_o = ser_val_q;
  assign busy_o         = busy_q;

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the parallel word width in bits (power of two, at least 4).
REQ-002 The block SHALL have parameter MOD_W, default $clog2(WIDTH), giving the width of the bit-count field.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port arst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port data_i, input, WIDTH bits: the parallel word; bit WIDTH-1 is sent first.
REQ-006 The block SHALL have port data_mod_i, input, MOD_W bits: the number of MSBs to send; 0 means WIDTH.
REQ-007 The block SHALL have port data_val_i, input, 1 bit: data_i and data_mod_i are valid this cycle.
REQ-008 The block SHALL have port ser_data_o, output, 1 bit: the serial data bit.
REQ-009 The block SHALL have port ser_data_val_o, output, 1 bit: ser_data_o is valid this cycle.
REQ-010 The block SHALL have port busy_o, output, 1 bit: a word is being shifted and inputs are ignored.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and SEND.
REQ-012 A word SHALL be accepted on the cycle where state is IDLE and data_val_i=1 and the effective length N is at least 3; N = WIDTH if data_mod_i=0, else N = data_mod_i.
REQ-013 Requests with data_mod_i equal to 1 or 2 SHALL be dropped silently: the FSM stays in IDLE and no output is produced.
REQ-014 On acceptance at edge T, the block SHALL latch data_i into a shift register, load a bit counter with N, and enter SEND.
REQ-015 In SEND, for cycles T+1 to T+N, the block SHALL drive ser_data_val_o=1 and busy_o=1, with ser_data_o equal to the register MSB; the register shifts left by one each cycle.
REQ-016 The block SHALL output data_i[WIDTH-1] down to data_i[WIDTH-N] in that order; the unused LSBs SHALL never be output.
REQ-017 The block SHALL return to IDLE at the edge ending cycle T+N; from T+N+1, busy_o=0 and ser_data_val_o=0.
REQ-018 data_val_i asserted during SEND SHALL be ignored: no queuing, and the word in progress is not disturbed.
REQ-019 There SHALL be no back-to-back words: a word accepted at T+N+1 produces output from T+N+2, leaving at least one idle cycle.
REQ-020 When ser_data_val_o=0, ser_data_o SHALL be driven 0.
REQ-021 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-022 The bit counter SHALL be MOD_W+1 bits wide, so that N=WIDTH is representable without wrap-around.

Reset
REQ-023 Asserting arst_n_i=0 SHALL immediately, without waiting for a clock edge, set the FSM to IDLE, clear the counter and shift register, and drive ser_data_o=0, ser_data_val_o=0, busy_o=0.
REQ-024 Reset asserted mid-word SHALL abort the word; no further bits of that word SHALL appear after release.
REQ-025 After release of arst_n_i, the block SHALL accept a word on the first rising clock edge.

Structure
REQ-026 The FSM state enum (IDLE, SEND) and the minimum-length constant (3) SHALL live in shared package serializer_pkg.
REQ-027 The block SHALL be a single module with no sub-module; the counter and shift register are internal.

Verification
REQ-028 WIDTH=16, data_i=16'hA5C3, data_mod_i=0, one data_val_i pulse -> 16 valid cycles carrying 1010010111000011, with busy_o high for exactly those 16 cycles.
REQ-029 data_i=16'hF000, data_mod_i=5 -> 5 valid cycles carrying 11110, then idle; bits 10..0 are never output.
REQ-030 data_mod_i=1, then data_mod_i=2, each with data_val_i -> ser_data_val_o and busy_o stay 0.
REQ-031 A second data_val_i with data_i=16'hFFFF during the third bit of a 16'h0000 word -> 16 zeros output, and the second word is dropped.
REQ-032 arst_n_i pulsed low during bit 7 of a 16-bit word -> outputs go to 0 immediately without waiting for a clock edge, and nothing further is output until the next word.
REQ-033 Loopback into the existing deserializer with WIDTH=8 and data_mod_i=0, for all 256 values -> every deserialized word equals the input word.
